nand_gate: RTL and testbench

//  Bitwise 2-input NAND primitive for the basic-gates library.
//  - Combinational output for direct logic use.
//  - Registered copy and a saturating output-transition counter for synchronous consumers and debug.
//  - Combinational path is independent of clock/reset, so the block works with clk/rst left unconnected.

---
 rtl/nand_gate.sv | 59 +++++
 tb/tb_nand_gate.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/nand_gate.sv
// nand_gate: bitwise 2-input NAND with registered copy
// and a saturating output-transition counter.
//
// Ports:
//   clk        rising-edge clock
//   rst        async active-high reset
//   a, b       operands (WIDTH lanes)
//   out        ~(a & b), combinational, not gated by clk/rst
//   out_q      out registered on clk, resets to all-ones
//   toggle_cnt cycles where out differed from out_q,
//              saturating at all-ones
module nand_gate #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic [CNT_W-1:0] toggle_cnt
);

  // NAND of all-zero inputs
  localparam logic [WIDTH-1:0] Q_RST = '1;
  localparam logic [CNT_W-1:0] C_MAX = '1;

  logic [WIDTH-1:0] r_q;
  logic [CNT_W-1:0] r_cnt;
  logic             w_chg;
  logic             w_sat;

  assign out = ~(a & b);

  // one count per cycle, however many lanes move
  assign w_chg = (out != r_q);
  assign w_sat = (r_cnt == C_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= Q_RST;
    end else begin
      r_q <= out;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_chg && !w_sat) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign out_q      = r_q;
  assign toggle_cnt = r_cnt;

endmodule

// File: tb/tb_nand_gate.sv
// tb_nand_gate: scoreboard bench for nand_gate
// across WIDTH/CNT_W variants.
module tb_nand_gate;

  logic       clk;
  logic       clk_en;
  logic       rst;

  logic       a0, b0, out0, q0;
  logic [7:0] cnt0;
  logic       a1, b1, out1, q1;
  logic [1:0] cnt1;
  logic [3:0] a2, b2, out2, q2;
  logic [7:0] cnt2;

  nand_gate #(.WIDTH(1), .CNT_W(8)) u0 (
    .clk(clk), .rst(rst),
    .a(a0), .b(b0),
    .out(out0), .out_q(q0),
    .toggle_cnt(cnt0)
  );

  nand_gate #(.WIDTH(1), .CNT_W(2)) u1 (
    .clk(clk), .rst(rst),
    .a(a1), .b(b1),
    .out(out1), .out_q(q1),
    .toggle_cnt(cnt1)
  );

  nand_gate #(.WIDTH(4), .CNT_W(8)) u2 (
    .clk(clk), .rst(rst),
    .a(a2), .b(b2),
    .out(out2), .out_q(q2),
    .toggle_cnt(cnt2)
  );

  initial clk = 1'b0;
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  typedef struct {
    int         sel;
    logic [7:0] exp;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  function automatic logic [7:0] actual(int sel);
    case (sel)
      0: return {7'b0, out0};
      1: return {7'b0, q0};
      2: return cnt0;
      3: return {7'b0, out1};
      4: return {7'b0, q1};
      5: return {6'b0, cnt1};
      6: return {4'b0, out2};
      7: return {4'b0, q2};
      default: return cnt2;
    endcase
  endfunction

  task automatic push(int sel, logic [7:0] e,
                      string name);
    exp_t x;
    x.sel  = sel;
    x.exp  = e;
    x.name = name;
    sb.push_back(x);
  endtask

  // monitor: compares as soon as an expectation lands
  initial begin
    exp_t       e;
    logic [7:0] act;
    forever begin
      wait (sb.size() > 0);
      e   = sb.pop_front();
      act = actual(e.sel);
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s: got %0h expected %0h",
                 e.name, act, e.exp);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL timeout: test did not complete");
    $fatal(1, "timeout");
  end

  logic [1:0] tt_ab  [4];
  logic       tt_out [4];

  initial begin
    tt_ab  = '{2'b00, 2'b01, 2'b10, 2'b11};
    tt_out = '{1'b1, 1'b1, 1'b1, 1'b0};
    clk_en = 1'b0;
    rst = 1'b1;
    a0 = 0; b0 = 0;
    a1 = 0; b1 = 0;
    a2 = '0; b2 = '0;
    #1;
    push(1, 8'h01, "rst_q0");
    push(2, 8'h00, "rst_cnt0");
    push(4, 8'h01, "rst_q1");
    push(5, 8'h00, "rst_cnt1");
    push(7, 8'h0f, "rst_q2");
    push(8, 8'h00, "rst_cnt2");
    #1;
    rst = 1'b0;

    // truth table, clock stopped
    for (int i = 0; i < 4; i++) begin
      {a0, b0} = tt_ab[i];
      #1;
      push(0, {7'b0, tt_out[i]},
           $sformatf("tt_%0d", i));
      #1;
    end
    push(1, 8'h01, "q0_idle");
    a0 = 0; b0 = 0;
    clk_en = 1'b1;

    // register latency
    @(negedge clk);
    rst = 1'b1;
    #1;
    rst = 1'b0;
    a0 = 1; b0 = 1;
    #1;
    push(1, 8'h01, "lat_before");
    push(0, 8'h00, "lat_out");
    @(posedge clk); #1;
    push(1, 8'h00, "lat_after");
    push(2, 8'h01, "lat_cnt");

    // async reset between edges
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    push(1, 8'h01, "arst_q0");
    push(2, 8'h00, "arst_cnt0");
    push(0, 8'h00, "arst_out0");
    @(negedge clk);
    rst = 1'b0;
    a0 = 0; b0 = 0;

    // toggle count and saturation
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (i < 5) begin
        {a0, b0} = (i % 2 == 0) ? 2'b11 : 2'b00;
      end
      {a1, b1} = (i % 2 == 0) ? 2'b11 : 2'b00;
      @(posedge clk); #1;
      if (i < 5) begin
        push(2, 8'(i + 1),
             $sformatf("tog_cnt0_%0d", i));
      end
      push(5, (i + 1 > 3) ? 8'd3 : 8'(i + 1),
           $sformatf("sat_cnt1_%0d", i));
    end
    push(2, 8'd5, "tog_cnt0_hold");

    // 4-lane
    @(negedge clk);
    a2 = 4'b1100;
    b2 = 4'b1010;
    #1;
    push(6, 8'h07, "w4_out");
    push(7, 8'h0f, "w4_q_before");
    push(8, 8'h00, "w4_cnt_before");
    @(posedge clk); #1;
    push(7, 8'h07, "w4_q_after");
    push(8, 8'h01, "w4_cnt_after");
    @(negedge clk);
    a2 = 4'hf;
    b2 = 4'hf;
    #1;
    push(6, 8'h00, "w4_out_ones");
    @(posedge clk); #1;
    push(7, 8'h00, "w4_q_ones");
    push(8, 8'h02, "w4_cnt_multilane");

    for (int k = 0; k < 100; k++) begin
      if (sb.size() > 0) #1;
    end
    if (sb.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d pending expected 0",
               sb.size());
    end
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
